// File: rtl/rx_gather.sv
// Packs runs of NBYTES received bytes into one block for the AES input FIFO,
// first byte in the top bits. Partial blocks are discarded after an
// inter-byte timeout; completed blocks meeting a full FIFO are dropped.
module rx_gather #(
  parameter int unsigned NBYTES      = 16,
  parameter int unsigned TIMEOUT_CYC = 200000,
  parameter int unsigned TW          = 18
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rx_done,
  input  logic [7:0]          rx_in,
  input  logic                fifo_full,
  output logic [8*NBYTES-1:0] block_out,
  output logic                block_valid,
  output logic [3:0]          byte_cnt,
  output logic                busy,
  output logic                timeout_err,
  output logic                overflow_err
);

  localparam int unsigned BW = 8 * NBYTES;

  logic [BW-1:0] shreg;
  logic [BW-1:0] shreg_next;
  logic [TW-1:0] timer;
  logic          last_byte;

  // Incoming byte enters at the bottom so the first byte ends up on top.
  assign shreg_next = {shreg[BW-9:0], rx_in};
  assign last_byte  = (byte_cnt == 4'(NBYTES - 1));

  // The collecting/idle state is carried entirely by byte_cnt.
  assign busy = (byte_cnt != 4'd0);

  // Byte collection, block hand-off, overflow drop and inter-byte timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg        <= '0;
      timer        <= '0;
      byte_cnt     <= 4'd0;
      block_out    <= '0;
      block_valid  <= 1'b0;
      timeout_err  <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      block_valid  <= 1'b0;
      timeout_err  <= 1'b0;
      overflow_err <= 1'b0;
      if (rx_done) begin
        // A byte always wins over a timeout landing in the same cycle.
        timer <= '0;
        shreg <= shreg_next;
        if (last_byte) begin
          byte_cnt <= 4'd0;
          if (!fifo_full) begin
            block_out   <= shreg_next;
            block_valid <= 1'b1;
          end else begin
            overflow_err <= 1'b1;
          end
        end else begin
          byte_cnt <= byte_cnt + 4'd1;
        end
      end else if (byte_cnt != 4'd0) begin
        if (timer == TW'(TIMEOUT_CYC - 1)) begin
          byte_cnt    <= 4'd0;
          timer       <= '0;
          shreg       <= '0;
          timeout_err <= 1'b1;
        end else begin
          timer <= timer + TW'(1);
        end
      end else begin
        timer <= '0;
      end
    end
  end

endmodule

// File: tb/tb_rx_gather.sv
// Directed bench for rx_gather with a short timeout.
module tb_rx_gather;

  localparam int unsigned NBYTES = 16;
  localparam int unsigned TO     = 50;

  logic         clk = 1'b0;
  logic         reset;
  logic         rx_done;
  logic [7:0]   rx_in;
  logic         fifo_full;
  logic [127:0] block_out;
  logic         block_valid;
  logic [3:0]   byte_cnt;
  logic         busy;
  logic         timeout_err;
  logic         overflow_err;

  int checks = 0;
  int errors = 0;
  int n_valid = 0;
  int n_to = 0;
  int n_ovf = 0;
  int base_to;
  int base_ovf;
  int base_valid;

  rx_gather #(.NBYTES(NBYTES), .TIMEOUT_CYC(TO), .TW(18)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_done     (rx_done),
    .rx_in       (rx_in),
    .fifo_full   (fifo_full),
    .block_out   (block_out),
    .block_valid (block_valid),
    .byte_cnt    (byte_cnt),
    .busy        (busy),
    .timeout_err (timeout_err),
    .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle.
  always @(negedge clk) begin
    if (block_valid)  n_valid++;
    if (timeout_err)  n_to++;
    if (overflow_err) n_ovf++;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_in   = b;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
  endtask

  // Sends bytes first..first+count-1 back to back.
  task automatic send_seq(input logic [7:0] first, input int count);
    for (int i = 0; i < count; i++) send_byte(first + 8'(i));
  endtask

  logic [7:0]   t1_bytes [16];
  logic [127:0] blk_b;

  initial begin
    t1_bytes = '{8'hAA, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77,
                 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
    reset = 1'b1; rx_done = 1'b0; rx_in = 8'h00; fifo_full = 1'b0;
    idle(2);
    check("rst_block_out", block_out, 128'h0);
    check("rst_flags", {124'h0, block_valid, busy, timeout_err, overflow_err}, 128'h0);
    check("rst_byte_cnt", 128'(byte_cnt), 128'h0);
    reset = 1'b0;
    idle(2);

    // 1: slow stream, one byte every 20 cycles
    for (int i = 0; i < 16; i++) begin
      send_byte(t1_bytes[i]);
      if (i == 4) check("t1_cnt5", 128'(byte_cnt), 128'd5);
      if (i == 4) check("t1_busy", 128'(busy), 128'd1);
      if (i < 15) begin
        check("t1_no_valid", 128'(block_valid), 128'd0);
        idle(19);
      end
    end
    check("t1_valid", 128'(block_valid), 128'd1);
    check("t1_block", block_out, 128'hAA112233445566778899AABBCCDDEEFF);
    check("t1_cnt0", 128'(byte_cnt), 128'd0);
    tick();
    check("t1_valid_1cyc", 128'(block_valid), 128'd0);
    check("t1_no_errs", 128'(n_to + n_ovf), 128'd0);
    idle(3);

    // 2: timeout after 5 bytes, then recovery
    base_to = n_to;
    send_seq(8'h50, 5);
    idle(TO - 1);
    check("t2_before_to", 128'(timeout_err), 128'd0);
    check("t2_cnt_held", 128'(byte_cnt), 128'd5);
    tick();
    check("t2_to_pulse", 128'(timeout_err), 128'd1);
    check("t2_cnt_clr", 128'(byte_cnt), 128'd0);
    idle(9);
    check("t2_to_once", 128'(n_to - base_to), 128'd1);
    send_seq(8'h00, 16);
    check("t2_valid", 128'(block_valid), 128'd1);
    check("t2_block", block_out, 128'h000102030405060708090A0B0C0D0E0F);
    idle(3);

    // 3: back-to-back blocks
    base_valid = n_valid;
    send_seq(8'hA0, 16);
    check("t3_a_valid", 128'(block_valid), 128'd1);
    check("t3_a_block", block_out, 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF);
    send_byte(8'hB0);
    check("t3_a_held", block_out, 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF);
    check("t3_b_cnt1", 128'(byte_cnt), 128'd1);
    send_seq(8'hB1, 15);
    check("t3_b_valid", 128'(block_valid), 128'd1);
    blk_b = 128'hB0B1B2B3B4B5B6B7B8B9BABBBCBDBEBF;
    check("t3_b_block", block_out, blk_b);
    idle(2);
    check("t3_two_pulses", 128'(n_valid - base_valid), 128'd2);

    // 4: fifo full on the completing byte
    base_ovf = n_ovf; base_valid = n_valid;
    send_seq(8'hC0, 15);
    fifo_full = 1'b1;
    send_byte(8'hCF);
    fifo_full = 1'b0;
    check("t4_no_valid", 128'(block_valid), 128'd0);
    check("t4_ovf", 128'(overflow_err), 128'd1);
    check("t4_block_kept", block_out, blk_b);
    check("t4_cnt0", 128'(byte_cnt), 128'd0);
    idle(2);
    check("t4_ovf_once", 128'(n_ovf - base_ovf), 128'd1);
    check("t4_valid_none", 128'(n_valid - base_valid), 128'd0);

    // 5: reset in the middle of a block
    base_to = n_to; base_ovf = n_ovf;
    send_seq(8'hD0, 7);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_cnt0", 128'(byte_cnt), 128'd0);
    check("t5_busy0", 128'(busy), 128'd0);
    check("t5_block_rst", block_out, 128'h0);
    idle(TO + 5);
    check("t5_no_errs", 128'(n_to - base_to + n_ovf - base_ovf), 128'd0);
    send_seq(8'h10, 16);
    check("t5_valid", 128'(block_valid), 128'd1);
    check("t5_block", block_out, 128'h101112131415161718191A1B1C1D1E1F);
    idle(3);

    // 6: byte arrives exactly when the timer reaches its limit
    base_to = n_to;
    send_seq(8'hE0, 3);
    idle(TO - 1);
    send_byte(8'hE3);
    check("t6_no_to", 128'(timeout_err), 128'd0);
    check("t6_cnt4", 128'(byte_cnt), 128'd4);
    idle(TO - 1);
    check("t6_timer_restart", 128'(n_to - base_to), 128'd0);
    tick();
    check("t6_late_to", 128'(timeout_err), 128'd1);
    check("t6_cnt_clr", 128'(byte_cnt), 128'd0);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
